dmem_dump_ctrl: RTL and testbench
=================================

// Module: dmem_dump_ctrl
// PURPOSE
//  Data-memory port controller between processor_arm and its data memory. In normal operation it
//  passes the CPU's data-memory address/write port straight through. On a dump request it stalls
//  the CPU, owns the memory port, and walks every data-memory word out on a valid/ready stream.
//  It then signals completion. Used by benches and the debug path to read back final memory state.
// PARAMETERS
//  N          64  data and address width (bits)
//  DEPTH      32  number of N-bit words in data memory to dump
//  BYTE_SHIFT 3   log2(bytes per word); dump byte address = index << BYTE_SHIFT
// PORTS
//  CLOCK_50     in   1                 system clock, rising edge
//  reset        in   1                 asynchronous, active-high reset
//  DM_addr      in   N                 CPU data-memory byte address
//  DM_writeData in   N                 CPU write data
//  DM_writeEnable in 1                 CPU write enable
//  dump         in   1                 dump request (level)
//  stall        out  1                 CPU must hold PC/state while high
//  mem_addr     out  N                 address to data memory
//  mem_wdata    out  N                 write data to data memory
//  mem_we       out  1                 write enable to data memory
//  mem_rdata    in   N                 memory read data, combinational from mem_addr
//  dump_valid   out  1                 dump beat valid
//  dump_ready   in   1                 consumer accepts beat
//  dump_data    out  N                 dumped word
//  dump_index   out  $clog2(DEPTH)     word index of current beat
//  dump_done    out  1                 all DEPTH words delivered
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE; stall=0, dump_valid=0, dump_data=0, dump_index=0,
//   dump_done=0. Memory port outputs are combinational from state and follow IDLE pass-through.
//  FSM states: IDLE, READ, SEND, DONE. stall = (state != IDLE), combinational.
//  IDLE: mem_addr=DM_addr, mem_wdata=DM_writeData, mem_we=DM_writeEnable.
//   If dump=1 at the clock edge, go to READ with idx=0.
//   A CPU write in that same cycle commits; it is not lost.
//  READ: mem_addr=idx<<BYTE_SHIFT, mem_we=0. At the edge, register dump_data<=mem_rdata,
//   dump_index<=idx, and dump_valid<=1. Go to SEND.
//  SEND: mem_we=0. dump_valid, dump_data and dump_index are held stable until dump_valid&dump_ready.
//   On that handshake edge: dump_valid<=0.
//   If idx==DEPTH-1, go to DONE. Otherwise idx<=idx+1 and go to READ.
//  Throughput: one beat per 2 cycles when dump_ready is high.
//  DONE: dump_done=1, stall=1, mem_we=0. Return to IDLE on the first edge with dump=0.
//   dump_done is 0 in every other state.
//  Deasserting dump during READ/SEND does not abort; the walk always completes all DEPTH words.
//  idx never wraps: the terminal check on DEPTH-1 precedes the increment.
//  mem_we is 0 in every non-IDLE state, so the memory image is frozen during the dump.
//  Reset mid-dump: all state clears immediately. A later dump restarts from index 0.
// TESTING
//  T1 reset=1 with arbitrary inputs -> stall=0, dump_valid=0, dump_done=0,
//     mem_addr==DM_addr and mem_we==DM_writeEnable.
//  T2 IDLE, DM_writeEnable=1, DM_addr=0x10, DM_writeData=0xA5 -> mem_we=1, mem_addr=0x10,
//     mem_wdata=0xA5 in the same cycle; stall=0.
//  T3 memory word i preloaded to i+100, dump_ready=1, dump pulsed high -> 32 beats,
//     dump_index 0..31, dump_data i+100, mem_addr i*8 during READ.
//     dump_done rises 64 cycles after the dump edge; mem_we=0 throughout.
//  T4 dump_ready=0 for 5 cycles at beat 3 -> dump_valid=1 and dump_data=103, dump_index=3
//     stable; next beat is index 4 only after ready returns.
//  T5 DM_writeEnable=1, DM_addr=0x18, DM_writeData=0xBEEF in the same cycle dump rises ->
//     write commits; beat index 3 carries 0xBEEF.
//  T6 reset asserted at beat 10 -> dump_valid, stall and dump_done drop asynchronously;
//     a subsequent dump starts again at dump_index=0.

Source files
------------

// File: rtl/dmem_dump_ctrl.sv
// Data-memory port controller: passes CPU accesses through when idle, and on a dump request
// stalls the CPU and streams every memory word out on a valid/ready interface.
module dmem_dump_ctrl #(
    parameter int unsigned N          = 64,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned BYTE_SHIFT = 3,
    localparam int unsigned IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    input  logic [N-1:0]  DM_addr,
    input  logic [N-1:0]  DM_writeData,
    input  logic          DM_writeEnable,
    input  logic          dump,
    output logic          stall,
    output logic [N-1:0]  mem_addr,
    output logic [N-1:0]  mem_wdata,
    output logic          mem_we,
    input  logic [N-1:0]  mem_rdata,
    output logic          dump_valid,
    input  logic          dump_ready,
    output logic [N-1:0]  dump_data,
    output logic [IW-1:0] dump_index,
    output logic          dump_done
);

    typedef enum logic [1:0] {StIdle, StRead, StSend, StDone} state_e;

    localparam logic [IW-1:0] LastIdx = IW'(DEPTH - 1);

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [N-1:0]  data_q, data_d;
    logic [IW-1:0] index_q, index_d;
    logic          valid_q, valid_d;
    logic [N-1:0]  dump_addr;

    assign dump_addr = N'(idx_q) << BYTE_SHIFT;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            data_q  <= '0;
            index_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            index_q <= index_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        data_d    = data_q;
        index_d   = index_q;
        valid_d   = valid_q;
        mem_addr  = dump_addr;
        mem_wdata = '0;
        mem_we    = 1'b0;
        dump_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                // A CPU write in the request cycle still commits at this edge.
                mem_addr  = DM_addr;
                mem_wdata = DM_writeData;
                mem_we    = DM_writeEnable;
                if (dump) begin
                    state_d = StRead;
                    idx_d   = '0;
                end
            end
            StRead: begin
                data_d  = mem_rdata;
                index_d = idx_q;
                valid_d = 1'b1;
                state_d = StSend;
            end
            StSend: begin
                if (valid_q && dump_ready) begin
                    valid_d = 1'b0;
                    // Terminal check before increment so idx never wraps.
                    if (idx_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = StRead;
                    end
                end
            end
            StDone: begin
                dump_done = 1'b1;
                if (!dump) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign stall      = (state_q != StIdle);
    assign dump_valid = valid_q;
    assign dump_data  = data_q;
    assign dump_index = index_q;

endmodule

// File: tb/tb_dmem_dump_ctrl.sv
// Randomized self-checking bench for dmem_dump_ctrl: a behavioural memory image predicts
// every dumped beat, and stall/handshake/latency rules are checked cycle by cycle.
module tb_dmem_dump_ctrl;

    localparam int N     = 64;
    localparam int DEPTH = 32;
    localparam int BS    = 3;
    localparam int IW    = 5;

    logic          CLOCK_50 = 1'b0;
    logic          reset;
    logic [N-1:0]  DM_addr, DM_writeData;
    logic          DM_writeEnable, dump, stall;
    logic [N-1:0]  mem_addr, mem_wdata, mem_rdata;
    logic          mem_we, dump_valid, dump_ready, dump_done;
    logic [N-1:0]  dump_data;
    logic [IW-1:0] dump_index;

    logic [N-1:0] mem     [DEPTH];
    logic [N-1:0] ref_mem [DEPTH];

    int n_tests = 0;
    int n_fail  = 0;

    dmem_dump_ctrl #(.N(N), .DEPTH(DEPTH), .BYTE_SHIFT(BS)) dut (
        .CLOCK_50       (CLOCK_50),
        .reset          (reset),
        .DM_addr        (DM_addr),
        .DM_writeData   (DM_writeData),
        .DM_writeEnable (DM_writeEnable),
        .dump           (dump),
        .stall          (stall),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_we         (mem_we),
        .mem_rdata      (mem_rdata),
        .dump_valid     (dump_valid),
        .dump_ready     (dump_ready),
        .dump_data      (dump_data),
        .dump_index     (dump_index),
        .dump_done      (dump_done)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Data memory: synchronous write, combinational read.
    always @(posedge CLOCK_50) if (mem_we) mem[mem_addr[BS+IW-1:BS]] <= mem_wdata;
    assign mem_rdata = mem[mem_addr[BS+IW-1:BS]];

    task automatic check_eq(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One idle CPU cycle: drive, check pass-through, advance to next negedge.
    task automatic cpu_cycle(input logic [N-1:0] a, input logic [N-1:0] d, input logic we);
        DM_addr = a; DM_writeData = d; DM_writeEnable = we;
        #1;
        check_eq("idle_stall", stall, 1'b0);
        check_eq("idle_addr", mem_addr, a);
        check_eq("idle_we", mem_we, we);
        if (we) begin
            check_eq("idle_wdata", mem_wdata, d);
            ref_mem[a[BS+IW-1:BS]] = d;
        end
        @(negedge CLOCK_50);
    endtask

    // mode 0: ready always high; 1: ready low 5 cycles at beat 3; 2: random ready and dump.
    task automatic run_dump(input int mode, input int stop_at, input logic wr,
                            input logic [N-1:0] wa, input logic [N-1:0] wd);
        int            nb = 0;
        int            hold = 0;
        bit            was_held = 0;
        bit            finished = 0;
        logic [N-1:0]  hd;
        logic [IW-1:0] hi;
        DM_writeEnable = wr; DM_addr = wa; DM_writeData = wd;
        dump = 1'b1; dump_ready = 1'($urandom);
        if (wr) ref_mem[wa[BS+IW-1:BS]] = wd;
        #1;
        check_eq("start_stall", stall, 1'b0);
        check_eq("start_we", mem_we, wr);
        for (int k = 0; k < 400 && !finished; k++) begin
            @(negedge CLOCK_50);
            DM_writeEnable = 1'($urandom);
            DM_addr        = {$urandom, $urandom};
            DM_writeData   = {$urandom, $urandom};
            dump           = (mode == 2) ? 1'($urandom) : 1'b0;
            check_eq("dump_stall", stall, 1'b1);
            check_eq("dump_we", mem_we, 1'b0);
            if (dump_done) begin
                check_eq("done_beats", nb, DEPTH);
                check_eq("done_valid", dump_valid, 1'b0);
                if (mode == 0) check_eq("done_latency", k, 2 * DEPTH);
                dump = 1'b1; DM_writeEnable = 1'b0;
                @(negedge CLOCK_50);
                check_eq("done_hold", dump_done, 1'b1);
                check_eq("done_hold_stall", stall, 1'b1);
                dump = 1'b0;
                @(negedge CLOCK_50);
                check_eq("idle_done", dump_done, 1'b0);
                check_eq("idle_stall_back", stall, 1'b0);
                finished = 1;
            end else if (dump_valid) begin
                if (was_held) begin
                    check_eq("held_data", dump_data, hd);
                    check_eq("held_index", dump_index, hi);
                end
                check_eq("beat_index", dump_index, nb[IW-1:0]);
                check_eq("beat_data", dump_data, ref_mem[nb]);
                if (nb == stop_at) begin
                    DM_writeEnable = 1'b0; dump = 1'b0;
                    #1 reset = 1'b1;
                    #1;
                    check_eq("rst_valid", dump_valid, 1'b0);
                    check_eq("rst_stall", stall, 1'b0);
                    check_eq("rst_done", dump_done, 1'b0);
                    check_eq("rst_index", dump_index, '0);
                    @(negedge CLOCK_50);
                    reset = 1'b0;
                    finished = 1;
                end else begin
                    if (mode == 0) dump_ready = 1'b1;
                    else if (mode == 1) begin
                        dump_ready = !(nb == 3 && hold < 5);
                        if (!dump_ready) hold++;
                    end else dump_ready = ($urandom_range(0, 2) != 0);
                    was_held = !dump_ready;
                    hd = dump_data;
                    hi = dump_index;
                    if (dump_ready) nb++;
                end
            end else begin
                check_eq("read_addr", mem_addr, N'(nb) << BS);
                was_held = 0;
                dump_ready = 1'($urandom);
            end
        end
        check_eq("dump_finished", finished, 1'b1);
        if (mode == 1) check_eq("ready_gap", hold, 5);
        DM_writeEnable = 1'b0; dump = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        reset = 1'b1; dump = 1'b0; dump_ready = 1'b0;
        // Reset with arbitrary inputs: ports pass through, no stall.
        for (int i = 0; i < 4; i++) begin
            DM_addr        = N'($urandom_range(0, DEPTH - 1)) << BS;
            DM_writeData   = {$urandom, $urandom};
            DM_writeEnable = 1'($urandom);
            dump_ready     = 1'($urandom);
            #1;
            check_eq("rst_stall", stall, 1'b0);
            check_eq("rst_valid", dump_valid, 1'b0);
            check_eq("rst_done", dump_done, 1'b0);
            check_eq("rst_addr", mem_addr, DM_addr);
            check_eq("rst_we", mem_we, DM_writeEnable);
            if (DM_writeEnable) ref_mem[DM_addr[BS+IW-1:BS]] = DM_writeData;
            @(negedge CLOCK_50);
        end
        DM_writeEnable = 1'b0;
        reset = 1'b0;
        @(negedge CLOCK_50);

        cpu_cycle(64'h10, 64'hA5, 1'b1);
        for (int i = 0; i < DEPTH; i++) cpu_cycle(N'(i) << BS, N'(i + 100), 1'b1);
        cpu_cycle(64'h0, 64'h0, 1'b0);

        run_dump(0, -1, 1'b0, '0, '0);
        run_dump(1, -1, 1'b0, '0, '0);
        run_dump(0, -1, 1'b1, 64'h18, 64'hBEEF);
        run_dump(2, 10, 1'b0, '0, '0);
        run_dump(0, -1, 1'b0, '0, '0);

        for (int r = 0; r < 3; r++) begin
            for (int j = 0; j < 6; j++)
                cpu_cycle(N'($urandom_range(0, DEPTH - 1)) << BS, {$urandom, $urandom},
                          1'($urandom));
            run_dump(2, -1, 1'($urandom), N'($urandom_range(0, DEPTH - 1)) << BS,
                     {$urandom, $urandom});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
